// File: rtl/uart_cmd_decoder.sv
// Host command parser: turns UART bytes into single-byte memory bus accesses,
// returns read data to the UART transmitter and owns the CPU/PPU halt line.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  ERR_VAL        = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_halt,
  output logic [7:0]  err_cnt
);
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_HALT  = 8'h06;
  localparam logic [7:0] OP_RUN   = 8'h07;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX} state_t;

  state_t        state;
  logic          is_write;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          known_op;
  logic          err_evt;

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign known_op = rx_data inside {OP_WRITE, OP_READ, OP_HALT, OP_RUN};

  // Every protocol fault in the current cycle collapses into a single increment.
  always_comb begin
    err_evt = 1'b0;
    case (state)
      IDLE:    err_evt = rx_valid && !known_op;
      ADDR_HI: err_evt = !rx_valid && tmo_hit;
      ADDR_LO: err_evt = rx_valid ? (!is_write && !cpu_halt) : tmo_hit;
      DATA:    err_evt = rx_valid ? !cpu_halt : tmo_hit;
      BUS:     err_evt = rx_valid || (!bus_ack && tmo_hit);
      TX:      err_evt = rx_valid;
      default: err_evt = 1'b0;
    endcase
  end

  // Bus handshake: bus_req rises on BUS entry with we/addr/wdata already stable,
  // stays high until the cycle bus_ack is sampled, and drops on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      tmo_cnt   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 8'h00;
      cpu_halt  <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      tmo_cnt  <= '0;
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OP_WRITE: begin is_write <= 1'b1; state <= ADDR_HI; end
              OP_READ:  begin is_write <= 1'b0; state <= ADDR_HI; end
              OP_HALT:  cpu_halt <= 1'b1;
              OP_RUN:   cpu_halt <= 1'b0;
              default:  ;
            endcase
          end
        end
        ADDR_HI: begin
          if (rx_valid) begin
            bus_addr[15:8] <= rx_data;
            state          <= ADDR_LO;
          end else if (tmo_hit) state <= IDLE;
          else tmo_cnt <= tmo_cnt + 1'b1;
        end
        ADDR_LO: begin
          if (rx_valid) begin
            bus_addr[7:0] <= rx_data;
            if (is_write) state <= DATA;
            else if (cpu_halt) begin
              bus_req <= 1'b1;
              bus_we  <= 1'b0;
              state   <= BUS;
            end else begin
              tx_data <= ERR_VAL;
              state   <= TX;
            end
          end else if (tmo_hit) state <= IDLE;
          else tmo_cnt <= tmo_cnt + 1'b1;
        end
        DATA: begin
          if (rx_valid) begin
            bus_wdata <= rx_data;
            if (cpu_halt) begin
              bus_req <= 1'b1;
              bus_we  <= 1'b1;
              state   <= BUS;
            end else state <= IDLE;
          end else if (tmo_hit) state <= IDLE;
          else tmo_cnt <= tmo_cnt + 1'b1;
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (is_write) state <= IDLE;
            else begin
              tx_data <= bus_rdata;
              // Launch straight from the ack when TX is free so tx_start follows bus_ack by one cycle.
              if (!tx_busy) begin
                tx_start <= 1'b1;
                state    <= IDLE;
              end else state <= TX;
            end
          end else if (tmo_hit) begin
            bus_req <= 1'b0;
            if (is_write) state <= IDLE;
            else begin
              tx_data <= ERR_VAL;
              state   <= TX;
            end
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        TX: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed command table, hand-written timing corners,
// and random command streams checked against a command-level reference model.
module tb_uart_cmd_decoder;
  logic        clk, rst, rx_valid, tx_busy, bus_ack;
  logic [7:0]  rx_data, bus_rdata;
  logic        tx_start, bus_req, bus_we, cpu_halt;
  logic [7:0]  tx_data, bus_wdata, err_cnt;
  logic [15:0] bus_addr;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(16), .ERR_VAL(8'hFF)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .cpu_halt(cpu_halt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [31:0] bytes;  // first byte in [31:24]
    int          nb;
    int          nreq;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          ntx;
    logic [7:0]  txd;
    logic        halt;
    logic [7:0]  err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // observation of the current command window
  int obs_nreq, obs_req_cyc, obs_unstable, obs_ntx;
  logic obs_we;
  logic [15:0] obs_addr;
  logic [7:0] obs_wdata, obs_txd;
  int req_cyc, ack_cyc, tx_cyc, last_cyc;
  logic prev_req = 1'b0;
  logic [24:0] held;

  // bus responder state
  logic resp_en = 1'b1, spur_en = 1'b0, acked = 1'b0;
  int dly = 0, dly_min = 3, dly_max = 3;
  logic [7:0] bus_mem [logic [15:0]];

  // reference model state
  logic [7:0] ref_mem [logic [15:0]];
  logic m_halt;
  logic [7:0] m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_nreq = 0; obs_req_cyc = 0; obs_unstable = 0; obs_ntx = 0;
    obs_we = 1'b0; obs_addr = 16'h0; obs_wdata = 8'h0; obs_txd = 8'h0;
    req_cyc = -100; ack_cyc = -100; tx_cyc = -100; last_cyc = 0;
  endtask

  // One clock: sample outputs at the falling edge, run the bus responder, then drive rx.
  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge clk);
    cyc++;
    if (bus_req) obs_req_cyc++;
    if (bus_req && !prev_req) begin
      obs_nreq++; obs_we = bus_we; obs_addr = bus_addr; obs_wdata = bus_wdata; req_cyc = cyc;
    end
    if (bus_req && prev_req && {bus_we, bus_addr, bus_wdata} != held) obs_unstable++;
    held = {bus_we, bus_addr, bus_wdata};
    prev_req = bus_req;
    if (tx_start) begin obs_ntx++; obs_txd = tx_data; tx_cyc = cyc; end
    bus_ack = 1'b0;
    bus_rdata = 8'($urandom);
    if (!bus_req) begin
      acked = 1'b0;
      dly = $urandom_range(dly_min, dly_max);
      bus_ack = spur_en && ($urandom_range(0, 7) == 0);
    end else if (resp_en && !acked) begin
      if (dly == 0) begin
        bus_ack = 1'b1; acked = 1'b1; ack_cyc = cyc;
        if (bus_we) bus_mem[bus_addr] = bus_wdata;
        else bus_rdata = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : dflt(bus_addr);
      end else dly--;
    end
    rx_valid = v;
    rx_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_busy = 1'b0;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] bytes, input int nb, input int max_gap);
    int g;
    clear_obs();
    for (int i = 0; i < nb; i++) begin
      g = (i == 0) ? 0 : $urandom_range(0, max_gap);
      repeat (g) cycle(1'b0, 8'h00);
      cycle(1'b1, bytes[31-8*i -: 8]);
      last_cyc = cyc;
    end
    repeat (14) cycle(1'b0, 8'h00);
  endtask

  task automatic compare_cmd(input string tag, input vec_t e);
    check($sformatf("%s nreq", tag), 32'(obs_nreq), 32'(e.nreq));
    if (e.nreq == 1) begin
      check($sformatf("%s we", tag), 32'(obs_we), 32'(e.we));
      check($sformatf("%s addr", tag), 32'(obs_addr), 32'(e.addr));
      if (e.we) check($sformatf("%s wdata", tag), 32'(obs_wdata), 32'(e.wdata));
      check($sformatf("%s req_latency", tag), 32'(req_cyc - last_cyc), 32'd1);
      check($sformatf("%s req_stable", tag), 32'(obs_unstable), 32'd0);
    end
    check($sformatf("%s ntx", tag), 32'(obs_ntx), 32'(e.ntx));
    if (e.ntx == 1) begin
      check($sformatf("%s tx_data", tag), 32'(obs_txd), 32'(e.txd));
      if (e.nreq == 1) check($sformatf("%s tx_latency", tag), 32'(tx_cyc - ack_cyc), 32'd1);
    end
    check($sformatf("%s cpu_halt", tag), 32'(cpu_halt), 32'(e.halt));
    check($sformatf("%s err_cnt", tag), 32'(err_cnt), 32'(e.err));
  endtask

  function automatic vec_t mk(input logic [31:0] bytes, input int nb, input int nreq,
                              input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                              input int ntx, input logic [7:0] txd, input logic halt,
                              input logic [7:0] err);
    vec_t v;
    v.bytes = bytes; v.nb = nb; v.nreq = nreq; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ntx = ntx; v.txd = txd; v.halt = halt; v.err = err;
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? 8'hFF : x + 8'd1;
  endfunction

  // Command-level model: predicts the bus access, the reply byte and the status after one command.
  task automatic model_cmd(input logic [31:0] bytes, input int nb, output vec_t e);
    logic [7:0] op;
    logic [15:0] a;
    op = bytes[31:24];
    a = bytes[23:8];
    e = mk(bytes, nb, 0, 1'b0, a, bytes[7:0], 0, 8'h00, 1'b0, 8'h00);
    if (op == 8'h02) begin
      e.we = 1'b1;
      if (m_halt) begin e.nreq = 1; ref_mem[a] = bytes[7:0]; end
      else m_err = sat_inc(m_err);
    end else if (op == 8'h03) begin
      e.ntx = 1;
      if (m_halt) begin e.nreq = 1; e.txd = ref_mem.exists(a) ? ref_mem[a] : dflt(a); end
      else begin e.txd = 8'hFF; m_err = sat_inc(m_err); end
    end else if (op == 8'h06) m_halt = 1'b1;
    else if (op == 8'h07) m_halt = 1'b0;
    else m_err = sat_inc(m_err);
    e.halt = m_halt;
    e.err = m_err;
  endtask

  vec_t tbl [11];
  vec_t e;
  logic [7:0] op, exp_d;
  int k, nb, b_cyc, stable_bad;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    bus_ack = 1'b0; bus_rdata = 8'h00;
    clear_obs();

    // reset values
    do_reset();
    check("rst tx_start", 32'(tx_start), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    check("rst bus_addr", 32'(bus_addr), 32'd0);
    check("rst bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst cpu_halt", 32'(cpu_halt), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);

    // directed table, applied back to back from reset
    bus_mem[16'h2007] = 8'h5C;
    tbl[0]  = mk(32'h06000000, 1, 0, 1'b0, 16'h0000, 8'h00, 0, 8'h00, 1'b1, 8'd0);
    tbl[1]  = mk(32'h028000A9, 4, 1, 1'b1, 16'h8000, 8'hA9, 0, 8'h00, 1'b1, 8'd0);
    tbl[2]  = mk(32'h03200700, 3, 1, 1'b0, 16'h2007, 8'h00, 1, 8'h5C, 1'b1, 8'd0);
    tbl[3]  = mk(32'h07000000, 1, 0, 1'b0, 16'h0000, 8'h00, 0, 8'h00, 1'b0, 8'd0);
    tbl[4]  = mk(32'h03123400, 3, 0, 1'b0, 16'h0000, 8'h00, 1, 8'hFF, 1'b0, 8'd1);
    tbl[5]  = mk(32'h02123456, 4, 0, 1'b0, 16'h0000, 8'h00, 0, 8'h00, 1'b0, 8'd2);
    tbl[6]  = mk(32'h55000000, 1, 0, 1'b0, 16'h0000, 8'h00, 0, 8'h00, 1'b0, 8'd3);
    tbl[7]  = mk(32'h06000000, 1, 0, 1'b0, 16'h0000, 8'h00, 0, 8'h00, 1'b1, 8'd3);
    tbl[8]  = mk(32'h03060600, 3, 1, 1'b0, 16'h0606, 8'h00, 1, 8'hA5, 1'b1, 8'd3);
    tbl[9]  = mk(32'h02060706, 4, 1, 1'b1, 16'h0607, 8'h06, 0, 8'h00, 1'b1, 8'd3);
    tbl[10] = mk(32'h03060700, 3, 1, 1'b0, 16'h0607, 8'h00, 1, 8'h06, 1'b1, 8'd3);
    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i].bytes, tbl[i].nb, 2);
      compare_cmd($sformatf("tbl%0d", i), tbl[i]);
    end

    // inter-byte timeout after 02,80
    do_reset();
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h80);
    repeat (16) cycle(1'b0, 8'h00);
    check("ibt err_before", 32'(err_cnt), 32'd0);
    cycle(1'b0, 8'h00);
    check("ibt err_after", 32'(err_cnt), 32'd1);
    cycle(1'b1, 8'h06);
    cycle(1'b0, 8'h00);
    check("ibt halt", 32'(cpu_halt), 32'd1);
    check("ibt err_kept", 32'(err_cnt), 32'd1);

    // bus timeout on a read: req held 16 cycles, then ERR_VAL reply
    do_reset();
    resp_en = 1'b0;
    cycle(1'b1, 8'h06);
    clear_obs();
    cycle(1'b1, 8'h03); cycle(1'b1, 8'h40); cycle(1'b1, 8'h00);
    repeat (24) cycle(1'b0, 8'h00);
    check("btmo req_cycles", 32'(obs_req_cyc), 32'd16);
    check("btmo ntx", 32'(obs_ntx), 32'd1);
    check("btmo tx_data", 32'(obs_txd), 32'hFF);
    check("btmo err", 32'(err_cnt), 32'd1);
    resp_en = 1'b1;

    // TX back-pressure with a stray byte while waiting
    do_reset();
    dly_min = 2; dly_max = 2;
    cycle(1'b1, 8'h06);
    tx_busy = 1'b1;
    clear_obs();
    cycle(1'b1, 8'h03); cycle(1'b1, 8'h40); cycle(1'b1, 8'h01);
    exp_d = dflt(16'h4001);
    repeat (8) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h02);
    stable_bad = 0;
    repeat (31) begin
      cycle(1'b0, 8'h00);
      if (tx_data !== exp_d) stable_bad++;
    end
    check("bp no_tx_while_busy", 32'(obs_ntx), 32'd0);
    check("bp tx_data_stable", 32'(stable_bad), 32'd0);
    tx_busy = 1'b0;
    b_cyc = cyc;
    repeat (6) cycle(1'b0, 8'h00);
    check("bp ntx", 32'(obs_ntx), 32'd1);
    check("bp tx_data", 32'(obs_txd), 32'(exp_d));
    check("bp tx_after_release", 32'(tx_cyc - b_cyc), 32'd1);
    check("bp err", 32'(err_cnt), 32'd1);
    check("bp nreq", 32'(obs_nreq), 32'd1);

    // reset in the middle of a bus access
    do_reset();
    resp_en = 1'b0;
    cycle(1'b1, 8'h06); cycle(1'b1, 8'h02); cycle(1'b1, 8'h12); cycle(1'b1, 8'h34);
    cycle(1'b1, 8'h56); cycle(1'b0, 8'h00); cycle(1'b0, 8'h00);
    check("rstmid req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    check("rstmid bus_req", 32'(bus_req), 32'd0);
    check("rstmid cpu_halt", 32'(cpu_halt), 32'd0);
    rst = 1'b0;
    resp_en = 1'b1;
    cycle(1'b1, 8'h55);
    cycle(1'b0, 8'h00);
    check("rstmid err", 32'(err_cnt), 32'd1);
    check("rstmid no_req", 32'(bus_req), 32'd0);

    // random command stream against the model, with spurious acks outside BUS
    do_reset();
    m_halt = 1'b0; m_err = 8'h00;
    dly_min = 0; dly_max = 4; spur_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3) begin op = 8'h02; nb = 4; end
      else if (k < 6) begin op = 8'h03; nb = 3; end
      else if (k < 8) begin op = 8'h06; nb = 1; end
      else if (k == 8) begin op = 8'h07; nb = 1; end
      else begin op = 8'($urandom_range(8, 255)); nb = 1; end
      model_cmd({op, 8'h40, 8'($urandom_range(0, 7)), 8'($urandom)}, nb, e);
      run_cmd(e.bytes, e.nb, 4);
      compare_cmd($sformatf("rnd%0d", n), e);
    end
    spur_en = 1'b0;

    // err_cnt saturation
    do_reset();
    repeat (254) cycle(1'b1, 8'h55);
    cycle(1'b0, 8'h00);
    check("sat err_254", 32'(err_cnt), 32'hFE);
    repeat (46) cycle(1'b1, 8'($urandom_range(8, 255)));
    cycle(1'b0, 8'h00);
    check("sat err_max", 32'(err_cnt), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Command parser between the host UART receiver and the system memory bus. It consumes bytes from the UART RX stage and decodes the host protocol: write, read, CPU halt and CPU release. It issues single-byte accesses on the CPU-side memory bus and returns read data to the UART TX stage. It also drives the CPU/PPU hold signal that gives the host ownership of the bus while ROM images are loaded.

Parameters:
TIMEOUT_CYCLES, 50000, idle cycles allowed between bytes of one command and while waiting for bus_ack before the command is abandoned
ERR_VAL, 8'hFF, byte returned to host when a read cannot be performed

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
rx_valid  input  1  one-cycle pulse per received byte
rx_data  input  8  received byte, valid with rx_valid
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
tx_data  output  8  byte to transmit, held from tx_start until next tx_start
tx_busy  input  1  UART TX active
bus_req  output  1  memory access request, held until bus_ack
bus_we  output  1  1=write, 0=read; stable while bus_req
bus_addr  output  16  access address; stable while bus_req
bus_wdata  output  8  write data; stable while bus_req
bus_ack  input  1  one-cycle completion strobe from bus
bus_rdata  input  8  read data, valid on bus_ack cycle
cpu_halt  output  1  1 = CPU/PPU held in reset, host owns bus
err_cnt  output  8  saturating protocol error counter

Behaviour:
- Reset values: tx_start=0, tx_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_halt=0, err_cnt=0. FSM is in IDLE and the timeout counter is 0.
- Opcodes:
  - 8'h02 WRITE: followed by addr_hi, addr_lo, data.
  - 8'h03 READ: followed by addr_hi, addr_lo.
  - 8'h06 HALT: sets cpu_halt=1.
  - 8'h07 RUN: sets cpu_halt=0.
- HALT and RUN take effect on the cycle after their rx_valid. They are single-byte commands, and the FSM stays in IDLE.
- Unknown opcode in IDLE: ignored, err_cnt+1.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX.
  - IDLE: 02 or 03 goes to ADDR_HI; the opcode is latched as is_write.
  - ADDR_HI: on byte, latch bus_addr[15:8] and go to ADDR_LO.
  - ADDR_LO: on byte, latch bus_addr[7:0]. If is_write, go to DATA. Otherwise go to BUS if cpu_halt=1, else go to TX with tx_data=ERR_VAL and err_cnt+1.
  - DATA: on byte, latch bus_wdata. If cpu_halt=1, go to BUS; otherwise drop the write, err_cnt+1, go to IDLE.
  - BUS: bus_req=1 and bus_we=is_write, asserted on the first cycle after the final command byte's rx_valid.
    - On bus_ack, bus_req=0 on the next cycle.
    - Write ack goes to IDLE.
    - Read ack captures bus_rdata into tx_data and goes to TX.
  - TX: when tx_busy=0, pulse tx_start for one cycle and go to IDLE. While tx_busy=1, wait with tx_data held.
- Latency: read with idle TX gives bus_req the cycle after the addr_lo pulse, and tx_start the cycle after bus_ack.
- Timeout: the counter clears on each accepted byte and on state entry, and counts in ADDR_HI, ADDR_LO, DATA and BUS. When it reaches TIMEOUT_CYCLES-1:
  - In a byte-wait state: go to IDLE, err_cnt+1.
  - In BUS, write: drop bus_req, go to IDLE, err_cnt+1.
  - In BUS, read: drop bus_req, load tx_data=ERR_VAL, go to TX, err_cnt+1.
- rx_valid while in BUS or TX: byte discarded, err_cnt+1, state unchanged.
- bus_ack outside BUS: ignored.
- bus_ack and timeout in the same cycle: ack wins.
- Byte values are never interpreted as opcodes mid-command. 8'h06 as an address or data byte is data.
- err_cnt saturates at 8'hFF.
- rst asserted mid-command: all state returns to reset values on the next edge. bus_req drops immediately, any partial command is lost, and cpu_halt returns to 0.

Test Plan:
- HALT then WRITE: bytes 06,02,80,00,A9 -> cpu_halt=1; one bus_req with we=1, addr=8000, wdata=A9, held until ack; err_cnt=0.
- READ with halt: bytes 03,20,07, bus responds ack with rdata=5C after 3 cycles -> bus_req one cycle after the 07 byte, we=0; tx_start pulses once with tx_data=5C.
- READ while running (cpu_halt=0): 03,12,34 -> no bus_req; tx_start with tx_data=FF; err_cnt=1.
- Inter-byte timeout (TIMEOUT_CYCLES=16): 02,80 then silence -> return to IDLE after 16 idle cycles, err_cnt=1. A following 06 halts correctly.
- TX back-pressure: read completes while tx_busy=1 for 40 cycles -> tx_start only on the first cycle with tx_busy=0, tx_data stable throughout. A byte arriving meanwhile increments err_cnt.
- Reset mid-access: rst during BUS state -> bus_req=0 and cpu_halt=0 next cycle. Unknown opcode 55 after reset -> err_cnt=1.
